// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with memory wait states.
// Optional perf counters behind `define MC_PERF_CNT_EN (outputs read 0 otherwise).
module mc_controller #(
  parameter int OP_W = 6,
  parameter int ST_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] opcode,
  input  logic [OP_W-1:0] funct,
  input  logic            alu_zero,
  input  logic            mem_ready,
  output logic            pc_we,
  output logic            ir_we,
  output logic            rf_we,
  output logic            dm_we,
  output logic [2:0]      alu_op,
  output logic            alu_src_b,
  output logic [1:0]      ext_op,
  output logic [1:0]      reg_dst,
  output logic [1:0]      wd_sel,
  output logic [1:0]      npc_sel,
  output logic [ST_W-1:0] state,
  output logic            instr_done,
  output logic [31:0]     cycle_cnt,
  output logic [31:0]     instr_cnt
);

  typedef enum logic [ST_W-1:0] {
    S_FETCH  = ST_W'(0),
    S_DECODE = ST_W'(1),
    S_EXEC   = ST_W'(2),
    S_MEM    = ST_W'(3),
    S_WB     = ST_W'(4)
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_ADDU, C_SUBU, C_ORI, C_LUI,
    C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR
  } cls_t;

  localparam logic [OP_W-1:0] OP_R   = OP_W'('h00);
  localparam logic [OP_W-1:0] OP_ORI = OP_W'('h0D);
  localparam logic [OP_W-1:0] OP_LUI = OP_W'('h0F);
  localparam logic [OP_W-1:0] OP_LW  = OP_W'('h23);
  localparam logic [OP_W-1:0] OP_SW  = OP_W'('h2B);
  localparam logic [OP_W-1:0] OP_BEQ = OP_W'('h04);
  localparam logic [OP_W-1:0] OP_J   = OP_W'('h02);
  localparam logic [OP_W-1:0] OP_JAL = OP_W'('h03);
  localparam logic [OP_W-1:0] F_ADDU = OP_W'('h21);
  localparam logic [OP_W-1:0] F_SUBU = OP_W'('h23);
  localparam logic [OP_W-1:0] F_JR   = OP_W'('h08);

  state_t state_q, state_d;
  cls_t   cls_q, cls_d, cls_dec;

  logic       pc_c, ir_c, rf_c, dm_c, done_c, srcb_c;
  logic [2:0] aop_c;
  logic [1:0] ext_c, rdst_c, wd_c, npc_c;

  always_comb begin
    cls_dec = C_NOP;
    case (opcode)
      OP_R: begin
        case (funct)
          F_ADDU:  cls_dec = C_ADDU;
          F_SUBU:  cls_dec = C_SUBU;
          F_JR:    cls_dec = C_JR;
          default: cls_dec = C_NOP;
        endcase
      end
      OP_ORI:  cls_dec = C_ORI;
      OP_LUI:  cls_dec = C_LUI;
      OP_LW:   cls_dec = C_LW;
      OP_SW:   cls_dec = C_SW;
      OP_BEQ:  cls_dec = C_BEQ;
      OP_J:    cls_dec = C_J;
      OP_JAL:  cls_dec = C_JAL;
      default: cls_dec = C_NOP;
    endcase
  end

  assign cls_d = (state_q == S_DECODE) ? cls_dec : cls_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cls_q   <= C_NOP;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    pc_c    = 1'b0;
    ir_c    = 1'b0;
    rf_c    = 1'b0;
    dm_c    = 1'b0;
    done_c  = 1'b0;
    aop_c   = 3'd0;
    srcb_c  = 1'b0;
    ext_c   = 2'd0;
    rdst_c  = 2'd0;
    wd_c    = 2'd0;
    npc_c   = 2'd0;
    // ALU/EXT selects stay stable from EXEC through MEM and WB
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      case (cls_q)
        C_SUBU, C_BEQ: aop_c = 3'd1;
        C_ORI: begin
          aop_c  = 3'd2;
          srcb_c = 1'b1;
        end
        C_LUI: begin
          aop_c  = 3'd3;
          srcb_c = 1'b1;
        end
        C_LW, C_SW: begin
          srcb_c = 1'b1;
          ext_c  = 2'd1;
        end
        default: aop_c = 3'd0;
      endcase
    end
    case (state_q)
      S_FETCH: begin
        pc_c    = mem_ready;
        ir_c    = mem_ready;
        state_d = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        done_c  = (cls_dec == C_NOP);
        state_d = (cls_dec == C_NOP) ? S_FETCH : S_EXEC;
      end
      S_EXEC: begin
        case (cls_q)
          C_ADDU, C_SUBU, C_ORI, C_LUI: state_d = S_WB;
          C_LW, C_SW: state_d = S_MEM;
          C_BEQ: begin
            npc_c  = 2'd1;
            pc_c   = alu_zero;
            done_c = 1'b1;
          end
          C_J, C_JAL: begin
            npc_c  = 2'd2;
            pc_c   = 1'b1;
            done_c = 1'b1;
            if (cls_q == C_JAL) begin
              rf_c   = 1'b1;
              rdst_c = 2'd2;
              wd_c   = 2'd2;
            end
          end
          C_JR: begin
            npc_c  = 2'd3;
            pc_c   = 1'b1;
            done_c = 1'b1;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (cls_q == C_SW) begin
          dm_c    = 1'b1;
          done_c  = mem_ready;
          state_d = mem_ready ? S_FETCH : S_MEM;
        end else if (cls_q == C_LW) begin
          state_d = mem_ready ? S_WB : S_MEM;
        end
      end
      S_WB: begin
        rf_c   = 1'b1;
        done_c = 1'b1;
        rdst_c = (cls_q == C_ADDU || cls_q == C_SUBU) ? 2'd1 : 2'd0;
        wd_c   = (cls_q == C_LW) ? 2'd1 : 2'd0;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset overrides every strobe and select combinationally
  always_comb begin
    pc_we      = reset & pc_c;
    ir_we      = reset & ir_c;
    rf_we      = reset & rf_c;
    dm_we      = reset & dm_c;
    instr_done = reset & done_c;
    alu_op     = reset ? aop_c  : 3'd0;
    alu_src_b  = reset & srcb_c;
    ext_op     = reset ? ext_c  : 2'd0;
    reg_dst    = reset ? rdst_c : 2'd0;
    wd_sel     = reset ? wd_c   : 2'd0;
    npc_sel    = reset ? npc_c  : 2'd0;
  end

  assign state = state_q;

`ifdef MC_PERF_CNT_EN
  logic [31:0] cyc_q, ins_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (instr_done) ins_q <= ins_q + 32'd1;
    end
  end

  assign cycle_cnt = cyc_q;
  assign instr_cnt = ins_q;
`else
  assign cycle_cnt = 32'd0;
  assign instr_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-instruction cycle plans are queued
// by the stimulus and checked cycle by cycle on the falling edge.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        reset, alu_zero, mem_ready;
  logic [5:0]  opcode, funct;
  logic        pc_we, ir_we, rf_we, dm_we, alu_src_b, instr_done;
  logic [2:0]  alu_op, state;
  logic [1:0]  ext_op, reg_dst, wd_sel, npc_sel;
  logic [31:0] cycle_cnt, instr_cnt;

  mc_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .ir_we(ir_we), .rf_we(rf_we), .dm_we(dm_we),
    .alu_op(alu_op), .alu_src_b(alu_src_b), .ext_op(ext_op),
    .reg_dst(reg_dst), .wd_sel(wd_sel), .npc_sel(npc_sel),
    .state(state), .instr_done(instr_done),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  // ctl = {state, pc, ir, rf, dm, done}
  // sel = {alu_op, src_b, ext, reg_dst, wd_sel, npc_sel}
  typedef struct packed {
    logic        rst;
    logic [7:0]  ctl;
    logic [11:0] sel;
    logic [11:0] msk;
  } rec_t;

  typedef struct {
    rec_t e;
    logic mr;
    logic az;
    logic ro;
  } cyc_t;

  localparam logic [11:0] M_ALU = 12'hFC0;
  localparam logic [11:0] M_RW  = 12'h03C;
  localparam logic [11:0] M_NPC = 12'h003;

  rec_t        sb[$];
  cyc_t        prog[$];
  int          tests = 0;
  int          fails = 0;
  bit          running = 1'b0;
  logic [31:0] ec = 32'd0;
  logic [31:0] ei = 32'd0;

  logic [5:0] op_t [13];
  logic [5:0] fn_t [13];

  always @(negedge clk) begin
    rec_t        r;
    logic [7:0]  a;
    logic [11:0] s;
    if (running) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard: DUT cycle with no expected entry");
      end else begin
        r = sb.pop_front();
        a = {state, pc_we, ir_we, rf_we, dm_we, instr_done};
        tests++;
        if (a !== r.ctl) begin
          fails++;
          $display("FAIL ctl {st,pc,ir,rf,dm,done}: got %b expected %b",
                   a, r.ctl);
        end
        s = {alu_op, alu_src_b, ext_op, reg_dst, wd_sel, npc_sel};
        tests++;
        if ((s & r.msk) !== (r.sel & r.msk)) begin
          fails++;
          $display("FAIL sel: got %b expected %b mask %b",
                   s, r.sel, r.msk);
        end
        if (!r.rst) begin
          ec = 32'd0;
          ei = 32'd0;
        end
        tests++;
        if ({cycle_cnt, instr_cnt} !== {ec, ei}) begin
          fails++;
          $display("FAIL counters: got %0d/%0d expected %0d/%0d",
                   cycle_cnt, instr_cnt, ec, ei);
        end
`ifdef MC_PERF_CNT_EN
        if (r.rst) begin
          ec = ec + 32'd1;
          if (r.ctl[0]) ei = ei + 32'd1;
        end
`endif
      end
    end
  end

  function automatic rec_t mk(input logic [2:0] st, input logic pc,
                              input logic ir, input logic rf,
                              input logic dm, input logic dn);
    rec_t r;
    r.rst = 1'b1;
    r.ctl = {st, pc, ir, rf, dm, dn};
    r.sel = 12'd0;
    r.msk = 12'd0;
    return r;
  endfunction

  function automatic rec_t ss(input rec_t r, input logic [11:0] v,
                              input logic [11:0] m);
    rec_t o;
    o = r;
    o.sel = v;
    o.msk = m;
    return o;
  endfunction

  function automatic rec_t rst_rec();
    rec_t r;
    r.rst = 1'b0;
    r.ctl = 8'd0;
    r.sel = 12'd0;
    r.msk = 12'hFFF;
    return r;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void add(input rec_t e, input logic mr,
                              input logic az, input logic ro);
    cyc_t c;
    c.e  = e;
    c.mr = mr;
    c.az = az;
    c.ro = ro;
    prog.push_back(c);
  endfunction

  // Expected cycle plan for one instruction, from the class rules
  task automatic gen(input int k, input logic z, input int wf,
                     input int wm);
    logic       nop, sw;
    logic [2:0] aop;
    prog.delete();
    for (int i = 0; i < wf; i++)
      add(ss(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 12'd0, M_NPC),
          1'b0, rb(), 1'b0);
    add(ss(mk(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), 12'd0, M_NPC),
        1'b1, rb(), 1'b0);
    nop = (k >= 10);
    add(mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, nop), rb(), rb(), 1'b1);
    if (!nop) begin
      case (k)
        0, 1, 2, 3: begin
          aop = 3'(k);
          add(ss(mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
                 {aop, (k >= 2), 2'd0, 6'd0}, M_ALU), rb(), rb(), 1'b1);
          add(ss(mk(3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1),
                 {6'd0, (k < 2) ? 2'd1 : 2'd0, 2'd0, 2'd0}, M_RW),
              rb(), rb(), 1'b1);
        end
        4, 5: begin
          sw = (k == 5);
          add(ss(mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
                 {3'd0, 1'b1, 2'd1, 6'd0}, M_ALU), rb(), rb(), 1'b1);
          for (int i = 0; i < wm; i++)
            add(ss(mk(3'd3, 1'b0, 1'b0, 1'b0, sw, 1'b0),
                   {3'd0, 1'b1, 2'd1, 6'd0}, M_ALU), 1'b0, rb(), 1'b1);
          add(ss(mk(3'd3, 1'b0, 1'b0, 1'b0, sw, sw),
                 {3'd0, 1'b1, 2'd1, 6'd0}, M_ALU), 1'b1, rb(), 1'b1);
          if (!sw)
            add(ss(mk(3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1),
                   {6'd0, 2'd0, 2'd1, 2'd0}, M_RW), rb(), rb(), 1'b1);
        end
        6: add(ss(mk(3'd2, z, 1'b0, 1'b0, 1'b0, 1'b1),
                  {3'd1, 7'd0, 2'd1}, 12'hE03), rb(), z, 1'b1);
        7: add(ss(mk(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1),
                  {10'd0, 2'd2}, M_NPC), rb(), rb(), 1'b1);
        8: add(ss(mk(3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1),
                  {6'd0, 2'd2, 2'd2, 2'd2}, M_RW | M_NPC), rb(), rb(), 1'b1);
        default: add(ss(mk(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1),
                        {10'd0, 2'd3}, M_NPC), rb(), rb(), 1'b1);
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int k, input logic z, input int wf,
                     input int wm, input int abort_at, input int nrst);
    gen(k, z, wf, wm);
    for (int i = 0; i < prog.size(); i++) begin
      if (i == abort_at) begin
        reset = 1'b0;
        for (int j = 0; j < nrst; j++) begin
          mem_ready = rb();
          sb.push_back(rst_rec());
          step();
        end
        return;
      end
      reset     = 1'b1;
      mem_ready = prog[i].mr;
      alu_zero  = prog[i].az;
      if (prog[i].ro) begin
        opcode = op_t[k];
        funct  = (op_t[k] == 6'h00) ? fn_t[k] : 6'($urandom);
      end else begin
        opcode = 6'($urandom);
        funct  = 6'($urandom);
      end
      sb.push_back(prog[i].e);
      step();
    end
  endtask

  initial begin
    int k, wf, wm, ab;
    op_t = '{6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04,
             6'h02, 6'h03, 6'h00, 6'h00, 6'h3F, 6'h00};
    fn_t = '{6'h21, 6'h23, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
             6'h00, 6'h00, 6'h08, 6'h00, 6'h00, 6'h22};
    reset     = 1'b0;
    mem_ready = 1'b1;
    alu_zero  = 1'b0;
    opcode    = 6'h00;
    funct     = 6'h00;
    step();
    running = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1;
      sb.push_back(rst_rec());
      step();
    end
    run(0, 1'b0, 0, 0, -1, 0);
    run(4, 1'b0, 0, 2, -1, 0);
    run(6, 1'b1, 0, 0, -1, 0);
    run(6, 1'b0, 0, 0, -1, 0);
    run(8, 1'b0, 0, 0, -1, 0);
    run(11, 1'b0, 0, 0, -1, 0);
    run(5, 1'b0, 0, 0, 3, 2);
    run(10, 1'b0, 1, 0, -1, 0);
    for (int n = 0; n < 400; n++) begin
      k  = int'($urandom_range(0, 12));
      wf = int'($urandom_range(0, 2));
      wm = int'($urandom_range(0, 2));
      ab = -1;
      if ($urandom_range(0, 9) == 0) ab = int'($urandom_range(0, 5));
      run(k, rb(), wf, wm, ab, int'($urandom_range(1, 3)));
    end
    running = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
